mem_bank_sync: RTL and testbench
================================

Name: mem_bank_sync

Overview:
- Parametrised single-port synchronous RAM/ROM bank for the 6502 system bus.
- Decodes its own address window (BASE..BASE+DEPTH-1).
- Registered read data, one-cycle latency. Self-clears to INIT_VALUE after reset via an internal init sequencer.
- Several instances share one CPU bus; each reports a hit so bus muxing selects the responding bank.

Parameters:
- WIDTH, 8, data word width in bits
- ADDR_WIDTH, 16, bus address width
- DEPTH, 256, words in bank; must satisfy BASE+DEPTH <= 2**ADDR_WIDTH
- BASE, 0, first bus address mapped to word 0
- READ_ONLY, 0, 1 = writes rejected (ROM behaviour after init)
- INIT_VALUE, 0, WIDTH-bit value written to every word during init

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  access request, qualified by !busy
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_WIDTH  bus address
- din  in  WIDTH  write data
- dout  out  WIDTH  registered read data
- rvalid  out  1  one-cycle pulse: dout holds fresh read data
- hit  out  1  combinational: addr inside window (independent of req)
- busy  out  1  init in progress; requests ignored
- err  out  1  one-cycle pulse: accepted in-window write while READ_ONLY=1

Behaviour:
- Reset (reset=1 at rising edge):
  - dout=0, rvalid=0, err=0, busy=1.
  - Init index set to 0; FSM enters INIT.
  - Bank contents are not touched during the reset cycle itself.
- FSM states: INIT, READY.
  - INIT: each cycle write INIT_VALUE to bank[idx] and increment idx. After writing idx=DEPTH-1, go to READY and deassert busy. busy is high for exactly DEPTH cycles after reset is released.
  - READY: stays in READY until the next reset.
  - Reset asserted mid-INIT restarts INIT at idx 0.
  - INIT writes ignore READ_ONLY.
- Decode:
  - hit = (addr >= BASE) && ((addr - BASE) < DEPTH).
  - Compare in ADDR_WIDTH+1 bits so no wrap-around aliasing.
  - local index = (addr - BASE), truncated to clog2(DEPTH) bits.
- Accepted access: req && !busy && hit, in READY.
  - Write, READ_ONLY=0: bank[local] <= din at that edge. rvalid=0.
  - Write, READ_ONLY=1: bank unchanged; err=1 for the next cycle.
  - Read: dout <= bank[local] at that edge; rvalid=1 for the following cycle. Latency is 1 cycle.
- Request while busy, or with hit=0: no bank or dout change, rvalid=0, err=0. The request is silently dropped; the requester retries.
- dout holds its last read value until the next accepted read or reset. It is never tri-stated.
- Back-to-back: a write at cycle N followed by a read of the same address at N+1 returns the new data at N+2.
- Full throughput: one accepted access per cycle.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from din on write and from INIT_VALUE on init.
  - Adds output port parity_err (1 bit, reset 0).
  - parity_err pulses with rvalid when the stored parity mismatches the read word.
  - Adds input port parity_inject (1 bit). When high during an accepted write, the stored parity bit is inverted.
- Not defined: no parity storage, and neither port exists.

Test Plan:
- Init: BASE=16'h0200, DEPTH=256, INIT_VALUE=8'hA5. Pulse reset for 1 cycle -> busy high for exactly 256 cycles. Then read 16'h0200 and 16'h02FF -> dout=8'hA5, with rvalid one cycle after each request.
- Write/read: write 8'h3C to 16'h0210, then read 16'h0210 on the next cycle -> dout=8'h3C with rvalid 2 cycles after the write. Write 8'h77 to 16'h0211, and 16'h0210 still reads 8'h3C.
- Window edges: read 16'h01FF and 16'h0300 -> hit=0, rvalid=0, dout unchanged. Window at BASE=16'hFF00, DEPTH=256: 16'hFFFF -> hit=1, 16'h0000 -> hit=0 (no aliasing).
- Busy/reset mid-init: assert reset at init cycle 100 -> busy stays high 256 more cycles. Requests issued while busy -> no rvalid, no bank change.
- ROM: READ_ONLY=1, write 8'h00 to 16'h0205 -> err pulse 1 cycle, and a subsequent read returns 8'hA5. Out-of-window write -> err=0.
- Parity (MEM_PARITY_EN): write 8'h01 with parity_inject=1, then read -> parity_err=1 with rvalid. Rewrite 8'h01 normally, then read -> parity_err=0.

Source files
------------

// File: rtl/mem_bank_sync_if.sv
// Bus bundle between a 6502-side requester and one mem_bank_sync bank.
// Parity sideband signals exist only when MEM_PARITY_EN is defined.
interface mem_bank_sync_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 16
);
  // Handshake: the requester holds req/we/addr/din for one clk edge. The bank
  // takes the request at that edge only if busy is low and hit is high;
  // otherwise it drops the request and the requester retries. A taken read
  // answers with a one-cycle rvalid pulse on the next cycle, with dout valid.
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      din;
  logic [WIDTH-1:0]      dout;
  logic                  rvalid;
  logic                  hit;
  logic                  busy;
  logic                  err;
`ifdef MEM_PARITY_EN
  logic                  parity_inject;
  logic                  parity_err;

  modport master (output req, we, addr, din, parity_inject,
                  input  dout, rvalid, hit, busy, err, parity_err);
  modport slave  (input  req, we, addr, din, parity_inject,
                  output dout, rvalid, hit, busy, err, parity_err);
`else
  modport master (output req, we, addr, din,
                  input  dout, rvalid, hit, busy, err);
  modport slave  (input  req, we, addr, din,
                  output dout, rvalid, hit, busy, err);
`endif
endinterface

// File: rtl/mem_bank_sync.sv
// Address-windowed synchronous RAM/ROM bank for the 6502 bus, self-filled with
// INIT_VALUE after reset. Define MEM_PARITY_EN for per-word even parity.
module mem_bank_sync #(
  parameter int                WIDTH      = 8,
  parameter int                ADDR_WIDTH = 16,
  parameter int                DEPTH      = 256,
  parameter int                BASE       = 0,
  parameter int                READ_ONLY  = 0,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_bank_sync_if.slave         bus,
  output logic                   o_dbg_state
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic                  w_init_we;
  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [WIDTH-1:0]      r_dout;
  logic                  r_rvalid;
  logic                  r_err;

  // One extra bit keeps the window compare free of wrap-around aliasing.
  logic [ADDR_WIDTH:0]   w_addr_ext;
  logic [ADDR_WIDTH:0]   w_off;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_local;
  logic                  w_acc;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_ro_wr;

  assign w_addr_ext = {1'b0, bus.addr};
  assign w_off      = w_addr_ext - (ADDR_WIDTH+1)'(BASE);
  assign w_hit      = (w_addr_ext >= (ADDR_WIDTH+1)'(BASE)) &&
                      (w_off < (ADDR_WIDTH+1)'(DEPTH));
  assign w_local    = w_off[IDX_W-1:0];

  assign w_acc   = bus.req && w_hit && (r_state == ST_READY);
  assign w_wr    = w_acc && bus.we && (READ_ONLY == 0);
  assign w_ro_wr = w_acc && bus.we && (READ_ONLY != 0);
  assign w_rd    = w_acc && !bus.we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_init_we) r_idx <= r_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_we   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we = 1'b1;
        if (r_idx == IDX_W'(DEPTH - 1)) w_state_nxt = ST_READY;
      end
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // Array has no reset: the reset cycle itself leaves contents alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_init_we)  r_mem[r_idx]   <= INIT_VALUE;
      else if (w_wr)  r_mem[w_local] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout   <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      r_err    <= w_ro_wr;
      if (w_rd) r_dout <= r_mem[w_local];
    end
  end

`ifdef MEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_parity_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_init_we)  r_par[r_idx]   <= ^INIT_VALUE;
      else if (w_wr)  r_par[w_local] <= (^bus.din) ^ bus.parity_inject;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_parity_err <= 1'b0;
    else       r_parity_err <= w_rd && ((^r_mem[w_local]) != r_par[w_local]);
  end

  assign bus.parity_err = r_parity_err;
`endif

  assign bus.dout    = r_dout;
  assign bus.rvalid  = r_rvalid;
  assign bus.err     = r_err;
  assign bus.hit     = w_hit;
  assign bus.busy    = (r_state == ST_INIT);
  assign o_dbg_state = (r_state == ST_READY);
endmodule

// File: tb/tb_mem_bank_sync.sv
// Directed bench for mem_bank_sync: a RAM bank at 0x0200, a window at 0xFF00
// and a ROM bank at 0x0200, all sharing clock and reset.
module tb_mem_bank_sync;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dbg_m, dbg_h, dbg_r;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_bank_sync_if #(.WIDTH(8), .ADDR_WIDTH(16)) m_if ();
  mem_bank_sync_if #(.WIDTH(8), .ADDR_WIDTH(16)) h_if ();
  mem_bank_sync_if #(.WIDTH(8), .ADDR_WIDTH(16)) r_if ();

  mem_bank_sync #(.WIDTH(8), .ADDR_WIDTH(16), .DEPTH(256), .BASE('h0200),
                  .READ_ONLY(0), .INIT_VALUE(8'hA5))
    u_ram (.clk(clk), .reset(reset), .bus(m_if), .o_dbg_state(dbg_m));
  mem_bank_sync #(.WIDTH(8), .ADDR_WIDTH(16), .DEPTH(256), .BASE('hFF00),
                  .READ_ONLY(0), .INIT_VALUE(8'h00))
    u_hi (.clk(clk), .reset(reset), .bus(h_if), .o_dbg_state(dbg_h));
  mem_bank_sync #(.WIDTH(8), .ADDR_WIDTH(16), .DEPTH(256), .BASE('h0200),
                  .READ_ONLY(1), .INIT_VALUE(8'hA5))
    u_rom (.clk(clk), .reset(reset), .bus(r_if), .o_dbg_state(dbg_r));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_wr(input logic [15:0] a, input logic [7:0] d);
    m_if.req = 1'b1; m_if.we = 1'b1; m_if.addr = a; m_if.din = d;
    tick();
    m_if.req = 1'b0;
  endtask

  task automatic m_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    m_if.req = 1'b1; m_if.we = 1'b0; m_if.addr = a;
    tick();
    m_if.req = 1'b0;
    check({tag, "_rvalid"}, 32'(m_if.rvalid), 32'd1);
    check({tag, "_dout"}, 32'(m_if.dout), 32'(exp));
  endtask

  // Counts cycles with busy high, optionally driving requests that must be dropped.
  task automatic count_busy(input int limit, input bit poke, output int cnt, output int rv_seen);
    cnt = 0;
    rv_seen = 0;
    while (m_if.busy && cnt < limit) begin
      if (poke) begin
        m_if.req = 1'b1; m_if.we = cnt[0]; m_if.addr = 16'h0210; m_if.din = 8'hFF;
      end
      cnt++;
      tick();
      if (m_if.rvalid) rv_seen++;
    end
    m_if.req = 1'b0;
  endtask

  initial begin
    int cnt;
    int rv;
    m_if.req = 0; m_if.we = 0; m_if.addr = '0; m_if.din = '0;
    h_if.req = 0; h_if.we = 0; h_if.addr = '0; h_if.din = '0;
    r_if.req = 0; r_if.we = 0; r_if.addr = '0; r_if.din = '0;
`ifdef MEM_PARITY_EN
    m_if.parity_inject = 0; h_if.parity_inject = 0; r_if.parity_inject = 0;
`endif

    // Reset and init length
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(m_if.busy), 32'd1);
    check("rst_dout", 32'(m_if.dout), 32'd0);
    check("rst_rvalid", 32'(m_if.rvalid), 32'd0);
    check("rst_err", 32'(r_if.err), 32'd0);
    count_busy(1000, 1'b0, cnt, rv);
    check("busy_len", 32'(cnt), 32'd256);
    check("dbg_ready", 32'(dbg_m), 32'd1);
    m_rd("init_lo", 16'h0200, 8'hA5);
    m_rd("init_hi", 16'h02FF, 8'hA5);
    tick();
    check("rvalid_pulse", 32'(m_if.rvalid), 32'd0);

    // Write then back-to-back read
    m_if.req = 1'b1; m_if.we = 1'b1; m_if.addr = 16'h0210; m_if.din = 8'h3C;
    tick();
    check("wr_rvalid", 32'(m_if.rvalid), 32'd0);
    m_if.we = 1'b0;
    tick();
    m_if.req = 1'b0;
    check("b2b_rvalid", 32'(m_if.rvalid), 32'd1);
    check("b2b_dout", 32'(m_if.dout), 32'h3C);
    m_wr(16'h0211, 8'h77);
    m_rd("keep_0210", 16'h0210, 8'h3C);
    m_rd("rd_0211", 16'h0211, 8'h77);

    // Window edges
    m_if.addr = 16'h01FF; #1;
    check("hit_01ff", 32'(m_if.hit), 32'd0);
    m_if.req = 1'b1; m_if.we = 1'b0;
    tick();
    m_if.req = 1'b0;
    check("miss_lo_rvalid", 32'(m_if.rvalid), 32'd0);
    check("miss_lo_dout", 32'(m_if.dout), 32'h77);
    m_if.addr = 16'h0300; #1;
    check("hit_0300", 32'(m_if.hit), 32'd0);
    m_if.req = 1'b1;
    tick();
    m_if.req = 1'b0;
    check("miss_hi_rvalid", 32'(m_if.rvalid), 32'd0);
    check("miss_hi_dout", 32'(m_if.dout), 32'h77);
    m_if.addr = 16'h02FF; #1;
    check("hit_02ff", 32'(m_if.hit), 32'd1);
    h_if.addr = 16'hFFFF; #1;
    check("hi_hit_ffff", 32'(h_if.hit), 32'd1);
    h_if.addr = 16'h0000; #1;
    check("hi_hit_0000", 32'(h_if.hit), 32'd0);
    h_if.addr = 16'hFEFF; #1;
    check("hi_hit_feff", 32'(h_if.hit), 32'd0);

    // ROM behaviour
    r_if.req = 1'b1; r_if.we = 1'b1; r_if.addr = 16'h0205; r_if.din = 8'h00;
    tick();
    r_if.req = 1'b0;
    check("rom_err", 32'(r_if.err), 32'd1);
    tick();
    check("rom_err_pulse", 32'(r_if.err), 32'd0);
    r_if.req = 1'b1; r_if.we = 1'b0;
    tick();
    r_if.req = 1'b0;
    check("rom_rvalid", 32'(r_if.rvalid), 32'd1);
    check("rom_dout", 32'(r_if.dout), 32'hA5);
    r_if.req = 1'b1; r_if.we = 1'b1; r_if.addr = 16'h0100;
    tick();
    r_if.req = 1'b0;
    check("rom_oow_err", 32'(r_if.err), 32'd0);

    // Reset mid-init, requests while busy
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy(100, 1'b0, cnt, rv);
    check("mid_cnt", 32'(cnt), 32'd100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_dout_rst", 32'(m_if.dout), 32'd0);
    count_busy(1000, 1'b1, cnt, rv);
    check("restart_len", 32'(cnt), 32'd256);
    check("busy_no_rvalid", 32'(rv), 32'd0);
    m_rd("reinit_0210", 16'h0210, 8'hA5);

`ifdef MEM_PARITY_EN
    m_if.parity_inject = 1'b1;
    m_wr(16'h0220, 8'h01);
    m_if.parity_inject = 1'b0;
    m_rd("par_bad", 16'h0220, 8'h01);
    check("par_err_set", 32'(m_if.parity_err), 32'd1);
    m_wr(16'h0220, 8'h01);
    m_rd("par_good", 16'h0220, 8'h01);
    check("par_err_clr", 32'(m_if.parity_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
